// File: rtl/lfsr_pkg.sv
// Shared types and default tap/seed constants for the LFSR pseudo-random generator.
// Tap masks are Fibonacci maximal-length polynomials.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RECOVER
    } lfsr_state_t;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    localparam logic [7:0]  SEED_8  = 8'h01;
    localparam logic [15:0] SEED_16 = 16'h0001;
    localparam logic [31:0] SEED_32 = 32'h0000_0001;

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational LFSR successor function, Fibonacci or Galois form.
// Also exposes the feedback bit of the current state.
module lfsr_next_state #(
    parameter int unsigned         WIDTH  = 8,
    parameter logic [WIDTH-1:0]    TAPS   = 8'hB8,
    parameter bit                  GALOIS = 1'b0
) (
    input  logic [WIDTH-1:0] st,
    output logic [WIDTH-1:0] nxt,
    output logic             fb
);

    generate
        if (GALOIS) begin : g_galois
            assign fb  = st[WIDTH-1];
            assign nxt = (st << 1) ^ (fb ? TAPS : '0);
        end else begin : g_fibonacci
            assign fb  = ^(st & TAPS);
            assign nxt = {st[WIDTH-2:0], fb};
        end
    endgenerate

endmodule

// File: rtl/lfsr_prng_gen.sv
// Parametrised LFSR pseudo-random generator with seed and output valid/ready streams.
// Optional feature macro: LFSR_PERIOD_CNT_EN adds a step counter and period_len output.
module lfsr_prng_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(TAPS_8),
    parameter bit               GALOIS = 1'b0,
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(SEED_8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_valid,
    input  logic [WIDTH-1:0] seed_data,
    output logic             seed_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_bit,
    output logic             lockup,
    output logic             wrap
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic [WIDTH-1:0] period_len
`endif
);

    lfsr_state_t      state_q, state_d;
    logic [WIDTH-1:0] st_q, st_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] nxt;
    logic             lockup_q, lockup_d;
    logic             wrap_q, wrap_d;
    logic             seed_fire, step_fire;

    lfsr_next_state #(
        .WIDTH  (WIDTH),
        .TAPS   (TAPS),
        .GALOIS (GALOIS)
    ) u_next_state (
        .st  (st_q),
        .nxt (nxt),
        .fb  (out_bit)
    );

    assign seed_ready = (state_q == IDLE);
    assign out_valid  = (state_q == RUN);
    assign out_data   = st_q;
    assign lockup     = lockup_q;
    assign wrap       = wrap_q;
    assign seed_fire  = seed_valid && seed_ready;
    assign step_fire  = out_valid && out_ready;

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
    assign period_len = period_q;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        st_d     = st_q;
        base_d   = base_q;
        lockup_d = 1'b0;
        wrap_d   = 1'b0;
`ifdef LFSR_PERIOD_CNT_EN
        cnt_d    = cnt_q;
        period_d = period_q;
`endif
        case (state_q)
            IDLE: begin
                if (seed_fire) begin
                    if (seed_data == '0) begin
                        st_d     = SEED;
                        base_d   = SEED;
                        lockup_d = 1'b1;
                    end else begin
                        st_d     = seed_data;
                        base_d   = seed_data;
                    end
`ifdef LFSR_PERIOD_CNT_EN
                    cnt_d = '0;
`endif
                end
                if (en) state_d = RUN;
            end
            RUN: begin
                if (step_fire && nxt == '0) begin
                    // A stuck-at-zero successor only arises from a degenerate tap mask.
                    state_d = RECOVER;
                end else begin
                    if (step_fire) begin
                        st_d   = nxt;
                        wrap_d = (nxt == base_q);
`ifdef LFSR_PERIOD_CNT_EN
                        if (nxt == base_q) begin
                            period_d = cnt_q + 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d    = cnt_q + 1'b1;
                        end
`endif
                    end
                    if (!en) state_d = IDLE;
                end
            end
            RECOVER: begin
                st_d     = SEED;
                base_d   = SEED;
                lockup_d = 1'b1;
                state_d  = en ? RUN : IDLE;
`ifdef LFSR_PERIOD_CNT_EN
                cnt_d    = '0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            st_q     <= SEED;
            base_q   <= SEED;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
`ifdef LFSR_PERIOD_CNT_EN
            cnt_q    <= '0;
            period_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            st_q     <= st_d;
            base_q   <= base_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
`ifdef LFSR_PERIOD_CNT_EN
            cnt_q    <= cnt_d;
            period_q <= period_d;
`endif
        end
    end

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Directed testbench for lfsr_prng_gen: default Fibonacci, Galois and degenerate-tap instances.
// Period length is checked only when LFSR_PERIOD_CNT_EN is defined.
module tb_lfsr_prng_gen;

    logic clk = 1'b0;
    logic clk_run = 1'b1;
    logic rst_n;

    always #5 clk = clk_run ? ~clk : clk;

    // Default instance (Fibonacci, TAPS=B8, SEED=01)
    logic       en, seed_valid, seed_ready, out_valid, out_ready, out_bit, lockup, wrap;
    logic [7:0] seed_data, out_data;
    // Degenerate instance (TAPS=00)
    logic       d_en, d_seed_valid, d_seed_ready, d_out_valid, d_out_ready, d_out_bit, d_lockup, d_wrap;
    logic [7:0] d_seed_data, d_out_data;
    // Galois instance (TAPS=1D)
    logic       g_en, g_seed_valid, g_seed_ready, g_out_valid, g_out_ready, g_out_bit, g_lockup, g_wrap;
    logic [7:0] g_seed_data, g_out_data;
`ifdef LFSR_PERIOD_CNT_EN
    logic [7:0] period_len, d_period_len, g_period_len;
`endif

    lfsr_prng_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bit(out_bit), .lockup(lockup), .wrap(wrap)
`ifdef LFSR_PERIOD_CNT_EN
        , .period_len(period_len)
`endif
    );

    lfsr_prng_gen #(.WIDTH(8), .TAPS(8'h00), .GALOIS(1'b0), .SEED(8'h01)) dut_d (
        .clk(clk), .rst_n(rst_n), .en(d_en),
        .seed_valid(d_seed_valid), .seed_data(d_seed_data), .seed_ready(d_seed_ready),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .out_bit(d_out_bit), .lockup(d_lockup), .wrap(d_wrap)
`ifdef LFSR_PERIOD_CNT_EN
        , .period_len(d_period_len)
`endif
    );

    lfsr_prng_gen #(.WIDTH(8), .TAPS(8'h1D), .GALOIS(1'b1), .SEED(8'h01)) dut_g (
        .clk(clk), .rst_n(rst_n), .en(g_en),
        .seed_valid(g_seed_valid), .seed_data(g_seed_data), .seed_ready(g_seed_ready),
        .out_valid(g_out_valid), .out_ready(g_out_ready), .out_data(g_out_data),
        .out_bit(g_out_bit), .lockup(g_lockup), .wrap(g_wrap)
`ifdef LFSR_PERIOD_CNT_EN
        , .period_len(g_period_len)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] fib_seq [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    logic       fib_bit [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] gal_seq [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
    int wraps;

    initial begin
        rst_n = 1'b0;
        {en, seed_valid, out_ready, seed_data} = '0;
        {d_en, d_seed_valid, d_out_ready, d_seed_data} = '0;
        {g_en, g_seed_valid, g_out_ready, g_seed_data} = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_seed_ready", 32'(seed_ready), 32'd1);
        check("rst_lockup", 32'(lockup), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h01);
        rst_n = 1'b1;

        // Default sequence 01,02,04,08,11
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("seq_data[%0d]", i), 32'(out_data), 32'(fib_seq[i]));
            check($sformatf("seq_bit[%0d]", i), 32'(out_bit), 32'(fib_bit[i]));
            check($sformatf("seq_valid[%0d]", i), 32'(out_valid), 32'd1);
            check($sformatf("seq_lockup[%0d]", i), 32'(lockup), 32'd0);
        end

        // Backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'h11);
        end
        out_ready = 1'b1;
        tick();
        check("bp_advance", 32'(out_data), 32'h23);
        out_ready = 1'b0;

        // Back to IDLE, then load seed 5A
        en = 1'b0;
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_seed_ready", 32'(seed_ready), 32'd1);
        seed_valid = 1'b1;
        seed_data  = 8'h5A;
        en         = 1'b1;
        tick();
        seed_valid = 1'b0;
        check("seed_data_5a", 32'(out_data), 32'h5A);
        check("seed_valid_out", 32'(out_valid), 32'd1);
        check("seed_ready_run", 32'(seed_ready), 32'd0);
        check("seed_no_lockup", 32'(lockup), 32'd0);

        out_ready = 1'b1;
        wraps = 0;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (wrap) wraps++;
        end
        check("wrap5a_count", 32'(wraps), 32'd1);
        check("wrap5a_pulse_last", 32'(wrap), 32'd1);
        check("wrap5a_data", 32'(out_data), 32'h5A);
`ifdef LFSR_PERIOD_CNT_EN
        check("wrap5a_period", 32'(period_len), 32'd255);
`endif
        out_ready = 1'b0;
        tick();
        check("wrap5a_one_cycle", 32'(wrap), 32'd0);

        // Zero seed replaced by SEED
        en = 1'b0;
        tick();
        seed_valid = 1'b1;
        seed_data  = 8'h00;
        tick();
        seed_valid = 1'b0;
        check("zseed_data", 32'(out_data), 32'h01);
        check("zseed_lockup", 32'(lockup), 32'd1);
        check("zseed_idle", 32'(out_valid), 32'd0);
        tick();
        check("zseed_lockup_clr", 32'(lockup), 32'd0);
        en = 1'b1;
        out_ready = 1'b1;
        tick();
        check("zseed_run_data", 32'(out_data), 32'h01);
        wraps = 0;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (wrap) wraps++;
        end
        check("zseed_wrap_count", 32'(wraps), 32'd1);
        check("zseed_wrap_data", 32'(out_data), 32'h01);
`ifdef LFSR_PERIOD_CNT_EN
        check("zseed_period", 32'(period_len), 32'd255);
`endif
        out_ready = 1'b0;

        // Degenerate taps: seed 80, one step -> RECOVER -> SEED
        d_seed_valid = 1'b1;
        d_seed_data  = 8'h80;
        d_en         = 1'b1;
        tick();
        d_seed_valid = 1'b0;
        check("deg_seed", 32'(d_out_data), 32'h80);
        check("deg_valid", 32'(d_out_valid), 32'd1);
        d_out_ready = 1'b1;
        tick();
        check("deg_recover_valid", 32'(d_out_valid), 32'd0);
        check("deg_recover_seed_ready", 32'(d_seed_ready), 32'd0);
        check("deg_recover_hold", 32'(d_out_data), 32'h80);
        check("deg_recover_lockup", 32'(d_lockup), 32'd0);
        tick();
        check("deg_after_data", 32'(d_out_data), 32'h01);
        check("deg_after_lockup", 32'(d_lockup), 32'd1);
        check("deg_after_valid", 32'(d_out_valid), 32'd1);
        d_out_ready = 1'b0;
        tick();
        check("deg_lockup_clr", 32'(d_lockup), 32'd0);

        // Galois form
        g_en = 1'b1;
        g_out_ready = 1'b1;
        tick();
        check("gal_first", 32'(g_out_data), 32'h01);
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("gal_data[%0d]", i), 32'(g_out_data), 32'(gal_seq[i]));
            check($sformatf("gal_bit[%0d]", i), 32'(g_out_bit), (gal_seq[i] == 8'h80) ? 32'd1 : 32'd0);
        end
        g_out_ready = 1'b0;

        // Asynchronous reset with the clock stopped
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pre_rst_data", 32'(out_data), 32'h02);
        @(negedge clk);
        clk_run = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'h01);
        check("arst_seed_ready", 32'(seed_ready), 32'd1);
        check("arst_g_data", 32'(g_out_data), 32'h01);
        check("arst_d_valid", 32'(d_out_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        clk_run = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
